alu_muldiv: RTL and testbench

- Parametrised successor to the pipeline's combinational ALU: same 4-bit operation encoding, generalised data width, registered outputs with a valid/ready handshake.
- Adds a multi-cycle iterative multiply/divide unit with HI/LO registers, MFHI and MFLO, to support the MIPS MULT/MULTU/DIV/DIVU instructions.
- Sits in the EX stage; the hazard unit stalls the pipeline while in_ready is low.

---
 rtl/alu_muldiv_if.sv | 25 ++
 rtl/alu_muldiv.sv | 217 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for alu_muldiv: operation request with in_valid/in_ready,
// registered result with a one-cycle out_valid pulse, plus the busy status.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Ctrl_alu;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] ALU_out;
    logic             zero;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, Ctrl_alu, input1, input2,
        input  in_ready, ALU_out, zero, out_valid, busy
    );

    modport slave (
        input  in_valid, Ctrl_alu, input1, input2,
        output in_ready, ALU_out, zero, out_valid, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// EX-stage ALU with registered outputs plus an iterative radix-2 multiply / restoring
// divide unit writing HI/LO (MIPS MULT/MULTU/DIV/DIVU, MFHI/MFLO).
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    logic [0:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   wrk_q, wrk_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res;
    logic               is_signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
    logic [2*WIDTH-1:0] fin_prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.ALU_out   = alu_out_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

    // One iteration step for each unit; only the one selected by is_div_q is committed.
    always_comb begin
        mul_sum      = wrk_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
        mul_next     = {mul_sum, wrk_q[WIDTH-1:1]};
        div_shift    = {acc_q, wrk_q[WIDTH-1]};
        div_trial    = div_shift - {1'b0, opb_q};
        div_ok       = !div_trial[WIDTH];
        div_rem_next = div_ok ? div_trial : div_shift;
        div_quo_next = {wrk_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        shamt = bus.input1[SHAMT_W-1:0];
        res   = '0;
        unique case (bus.Ctrl_alu)
            OP_ADD:  res = bus.input1 + bus.input2;
            OP_SUB:  res = bus.input1 - bus.input2;
            OP_SLL:  res = bus.input2 << shamt;
            OP_SRL:  res = bus.input2 >> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.input1) < $signed(bus.input2))};
            OP_AND:  res = bus.input1 & bus.input2;
            OP_OR:   res = bus.input1 | bus.input2;
            OP_XOR:  res = bus.input1 ^ bus.input2;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
            OP_SRA:  res = $signed(bus.input2) >>> shamt;
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase

        is_signed_op = (bus.Ctrl_alu == OP_MULT) || (bus.Ctrl_alu == OP_DIV);
        a_neg        = is_signed_op && bus.input1[WIDTH-1];
        b_neg        = is_signed_op && bus.input2[WIDTH-1];
        mag_a        = a_neg ? -bus.input1 : bus.input1;
        mag_b        = b_neg ? -bus.input2 : bus.input2;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        wrk_d       = wrk_q;
        opb_d       = opb_q;
        dvd_d       = dvd_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        div0_d      = div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        fin_prod    = '0;
        fin_hi      = '0;
        fin_lo      = '0;

        if (state_q == ST_IDLE) begin
            if (bus.in_valid) begin
                if (bus.Ctrl_alu inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
                    // Both units start from a zero accumulator with |A| in the shifting register.
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    wrk_d    = mag_a;
                    opb_d    = mag_b;
                    dvd_d    = bus.input1;
                    is_div_d = (bus.Ctrl_alu == OP_DIV) || (bus.Ctrl_alu == OP_DIVU);
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    div0_d   = (bus.input2 == '0);
                end else begin
                    alu_out_d   = res;
                    zero_d      = (res == '0);
                    out_valid_d = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
                acc_d = div_rem_next[WIDTH-1:0];
                wrk_d = div_quo_next;
            end else begin
                acc_d = mul_next[2*WIDTH-1:WIDTH];
                wrk_d = mul_next[WIDTH-1:0];
            end

            if (cnt_q == LAST_ITER) begin
                if (is_div_q) begin
                    fin_lo = neg_lo_q ? -div_quo_next : div_quo_next;
                    fin_hi = neg_hi_q ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
                    if (div0_q) begin
                        fin_lo = '1;
                        fin_hi = dvd_q;
                    end
                end else begin
                    fin_prod = neg_lo_q ? -mul_next : mul_next;
                    fin_hi   = fin_prod[2*WIDTH-1:WIDTH];
                    fin_lo   = fin_prod[WIDTH-1:0];
                end
                state_d     = ST_IDLE;
                cnt_d       = '0;
                hi_d        = fin_hi;
                lo_d        = fin_lo;
                alu_out_d   = fin_lo;
                zero_d      = (fin_lo == '0);
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            wrk_q       <= '0;
            opb_q       <= '0;
            dvd_q       <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div0_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            alu_out_q   <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            wrk_q       <= wrk_d;
            opb_q       <= opb_d;
            dvd_q       <= dvd_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            div0_q      <= div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a 32-bit instance for the full op set and an
// 8-bit instance for the parametric multiply and narrow shift amount.
module tb_alu_muldiv;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_muldiv_if #(.WIDTH(32)) bus  ();
    alu_muldiv_if #(.WIDTH(8))  bus8 ();

    alu_muldiv #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Ctrl_alu = op;
        bus.input1   = a;
        bus.input2   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk(tag, 64'(bus.ALU_out), 64'(exp));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp == 32'd0));
    endtask

    // Counts busy cycles until out_valid, bounded; in_ready must be !busy throughout.
    task automatic wait_done(input string tag, output int cyc);
        int  guard;
        bit  seen;
        bit  rdy_bad;
        cyc = 0; guard = 0; seen = 1'b0; rdy_bad = 1'b0;
        while (!seen && guard < 100) begin
            if (bus.busy) cyc++;
            if (bus.in_ready === bus.busy) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (bus.out_valid) seen = 1'b1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_ready"}, 64'(rdy_bad), 64'd0);
    endtask

    task automatic muldiv(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cyc;
        issue(op, a, b);
        chk({tag, "_busy0"}, 64'(bus.busy), 64'd1);
        wait_done(tag, cyc);
        chk({tag, "_cycles"}, 64'(cyc), 64'd32);
        chk({tag, "_lo"}, 64'(bus.ALU_out), 64'(exp_lo));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_lo == 32'd0));
        single({tag, "_mfhi"}, 4'b1110, 32'd0, 32'd0, exp_hi);
        single({tag, "_mflo"}, 4'b1111, 32'd0, 32'd0, exp_lo);
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.Ctrl_alu = op;
        bus8.input1   = a;
        bus8.input2   = b;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int guard;
        int spurious;
        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0; bus.Ctrl_alu  = 4'd0; bus.input1  = '0; bus.input2  = '0;
        bus8.in_valid = 1'b0; bus8.Ctrl_alu = 4'd0; bus8.input1 = '0; bus8.input2 = '0;
        rst_n = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_alu_out", 64'(bus.ALU_out), 64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd1);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Single-cycle ops, issued back to back every cycle.
        single("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0);
        single("sub",      4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single("sra",      4'b1001, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        single("sll",      4'b0010, 32'd16, 32'h1, 32'h0001_0000);
        single("srl_lowbits", 4'b0011, 32'h24, 32'hF0, 32'hF);
        single("slt",      4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h1);
        single("sltu",     4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0);
        single("and",      4'b0101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        single("or",       4'b0110, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        single("xor",      4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        @(posedge clk);
        #1;
        chk("pulse_drop", 64'(bus.out_valid), 64'd0);
        chk("hold_out", 64'(bus.ALU_out), 64'h5555_5555);

        muldiv("mult",     4'b1010, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        muldiv("multu",    4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        muldiv("div_neg",  4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        muldiv("div_ovf",  4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        muldiv("divu_0",   4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        muldiv("divu",     4'b1101, 32'd100, 32'd7, 32'd14, 32'd2);

        // Held add during MULTU: accepted only once in_ready returns.
        issue(4'b1011, 32'd3, 32'd4);
        bus.in_valid = 1'b1;
        bus.Ctrl_alu = 4'b0000;
        bus.input1   = 32'd10;
        bus.input2   = 32'd20;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("stall_done", 64'(bus.out_valid), 64'd1);
        chk("stall_mul", 64'(bus.ALU_out), 64'd12);
        chk("stall_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("stall_add_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_add", 64'(bus.ALU_out), 64'd30);

        // Async reset at iteration 10 of a multiply.
        issue(4'b1011, 32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_alu_out", 64'(bus.ALU_out), 64'd0);
        chk("abort_zero", 64'(bus.zero), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) spurious++;
        end
        chk("abort_no_valid", 64'(spurious), 64'd0);
        single("abort_mfhi", 4'b1110, 32'd0, 32'd0, 32'd0);
        single("abort_mflo", 4'b1111, 32'd0, 32'd0, 32'd0);

        // WIDTH=8 instance.
        issue8(4'b1011, 8'hFF, 8'hFF);
        cyc = 0; guard = 0;
        while (!bus8.out_valid && guard < 50) begin
            if (bus8.busy) cyc++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("w8_done", 64'(bus8.out_valid), 64'd1);
        chk("w8_cycles", 64'(cyc), 64'd8);
        chk("w8_lo", 64'(bus8.ALU_out), 64'h01);
        issue8(4'b1110, 8'h0, 8'h0);
        chk("w8_mfhi", 64'(bus8.ALU_out), 64'hFE);
        issue8(4'b0011, 8'h0B, 8'h80);
        chk("w8_srl_valid", 64'(bus8.out_valid), 64'd1);
        chk("w8_srl", 64'(bus8.ALU_out), 64'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
